// File: rtl/jt49_arb_pkg.sv
// Shared types and constants for the JT49 register-port arbiter.
package jt49_arb_pkg;

  // Bus sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RD1     = 3'd3,
    ST_RD2     = 3'd4,
    ST_RECOVER = 3'd5
  } arb_state_e;

  // Envelope shape register: every write to it must reach the PSG
  localparam logic [3:0] REG_ENV_SHAPE = 4'hD;

  // One register write request
  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } arb_req_t;

endpackage

// File: rtl/jt49_arb_fifo.sv
// Synchronous FIFO holding player register-write requests.
// DEPTH must be a power of two so the pointers wrap naturally.
module jt49_arb_fifo
  import jt49_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  arb_req_t               wdata_i,
  output arb_req_t               rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  arb_req_t        mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [AW:0]     level_q;
  logic            do_push_s;
  logic            do_pop_s;

  assign full_o    = (level_q == (AW+1)'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rdata_o   = mem_q[rptr_q];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Storage array: written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push_s) wptr_q <= wptr_q + 1'b1;
      if (do_pop_s)  rptr_q <= rptr_q + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/jt49_bus_arb.sv
// Arbiter and bus-cycle sequencer in front of the jt49 register port.
// CPU (read/write) and a FIFO-buffered player (write-only) share the port;
// every access is a setup/strobe/recover cycle so each write has its own wr_n edge.
// Optional build macro: JT49_ARB_SHADOW_EN elides writes that would not change
// a register (except the envelope shape register).
module jt49_bus_arb
  import jt49_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_CYC     = 2,
  parameter int GAP_CYC    = 1,
  parameter int CPU_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [3:0]                  cpu_addr,
  input  logic [7:0]                  cpu_wdata,
  output logic                        cpu_ack,
  output logic [7:0]                  cpu_rdata,
  output logic                        cpu_rvalid,
  input  logic                        ply_valid,
  output logic                        ply_ready,
  input  logic [3:0]                  ply_addr,
  input  logic [7:0]                  ply_data,
  output logic [$clog2(FIFO_DEPTH):0] ply_level,
  output logic                        busy,
  output logic                        psg_cs_n,
  output logic                        psg_wr_n,
  output logic [3:0]                  psg_addr,
  output logic [7:0]                  psg_din,
  input  logic [7:0]                  psg_dout
);

  localparam int BW = $clog2(CPU_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(CPU_BURST);

  arb_state_e state_q, state_d;
  logic [3:0]    cyc_q, cyc_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          own_cpu_q, own_cpu_d;
  logic          cs_n_q, cs_n_d, wr_n_q, wr_n_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    din_q, din_d, rdata_q, rdata_d;
  logic          ack_q, ack_d, rvalid_q, rvalid_d;

  arb_req_t      ply_req_s, head_s;
  logic          push_s, pop_s, full_s, empty_s, ply_win_s;
  logic [$clog2(FIFO_DEPTH):0] level_s;

  assign ply_req_s = '{addr: ply_addr, data: ply_data};
  assign push_s    = ply_valid & ~full_s;
  assign ply_win_s = ~empty_s & (~cpu_req | (burst_q == BURST_MAX));

  jt49_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (ply_req_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (level_s)
  );

`ifdef JT49_ARB_SHADOW_EN
  logic [7:0] shadow_q [16];
  logic       ply_hit_s, cpu_hit_s, shw_en_s;
  logic [3:0] shw_addr_s;
  logic [7:0] shw_data_s;

  assign ply_hit_s  = (shadow_q[head_s.addr] == head_s.data) && (head_s.addr != REG_ENV_SHAPE);
  assign cpu_hit_s  = (shadow_q[cpu_addr] == cpu_wdata) && (cpu_addr != REG_ENV_SHAPE);
  assign shw_en_s   = (state_q == ST_IDLE) && (ply_win_s || (cpu_req && cpu_we));
  assign shw_addr_s = ply_win_s ? head_s.addr : cpu_addr;
  assign shw_data_s = ply_win_s ? head_s.data : cpu_wdata;

  // Shadow copy of the last value granted to each register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) shadow_q[i] <= 8'h00;
    end else if (shw_en_s) begin
      shadow_q[shw_addr_s] <= shw_data_s;
    end
  end
`else
  logic ply_hit_s, cpu_hit_s;
  assign ply_hit_s = 1'b0;
  assign cpu_hit_s = 1'b0;
`endif

  // Arbitration, next state and next registered bus/handshake outputs
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    burst_d   = burst_q;
    own_cpu_d = own_cpu_q;
    cs_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    addr_d    = addr_q;
    din_d     = din_q;
    ack_d     = 1'b0;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ply_win_s) begin
          pop_s     = 1'b1;
          burst_d   = '0;
          own_cpu_d = 1'b0;
          if (ply_hit_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SETUP;
            cs_n_d  = 1'b0;
            addr_d  = head_s.addr;
            din_d   = head_s.data;
          end
        end else if (cpu_req) begin
          own_cpu_d = 1'b1;
          if (burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
          else                      burst_d = burst_q;
          if (!cpu_we) begin
            state_d = ST_RD1;
            cs_n_d  = 1'b0;
            addr_d  = cpu_addr;
          end else if (cpu_hit_s) begin
            state_d = ST_IDLE;
            ack_d   = 1'b1;
          end else begin
            state_d = ST_SETUP;
            cs_n_d  = 1'b0;
            addr_d  = cpu_addr;
            din_d   = cpu_wdata;
          end
        end else begin
          burst_d = '0;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cs_n_d  = 1'b0;
        wr_n_d  = 1'b0;
        cyc_d   = 4'(WR_CYC - 1);
      end
      ST_STROBE: begin
        if (cyc_q == 4'd0) begin
          state_d = ST_RECOVER;
          cyc_d   = 4'(GAP_CYC - 1);
          ack_d   = own_cpu_q;
        end else begin
          cyc_d  = cyc_q - 4'd1;
          cs_n_d = 1'b0;
          wr_n_d = 1'b0;
        end
      end
      ST_RD1: begin
        state_d = ST_RD2;
        cs_n_d  = 1'b0;
      end
      ST_RD2: begin
        state_d  = ST_RECOVER;
        cyc_d    = 4'(GAP_CYC - 1);
        ack_d    = 1'b1;
        rvalid_d = 1'b1;
        rdata_d  = psg_dout;
      end
      ST_RECOVER: begin
        if (cyc_q == 4'd0) state_d = ST_IDLE;
        else               cyc_d   = cyc_q - 4'd1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 4'd0;
      burst_q   <= '0;
      own_cpu_q <= 1'b0;
      cs_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      addr_q    <= 4'd0;
      din_q     <= 8'h00;
      ack_q     <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      burst_q   <= burst_d;
      own_cpu_q <= own_cpu_d;
      cs_n_q    <= cs_n_d;
      wr_n_q    <= wr_n_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      ack_q     <= ack_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign psg_cs_n   = cs_n_q;
  assign psg_wr_n   = wr_n_q;
  assign psg_addr   = addr_q;
  assign psg_din    = din_q;
  assign cpu_ack    = ack_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign ply_ready  = ~full_s;
  assign ply_level  = level_s;
  assign busy       = (state_q != ST_IDLE) | ~empty_s;

endmodule
